// File: rtl/registro_datos_pkg.sv
// Shared constants for the data register: default word width and the
// legal range of pipeline depth, plus a helper to validate that depth.
package registro_datos_pkg;

    localparam int BYTE_W     = 8;
    localparam int MIN_STAGES = 1;
    localparam int MAX_STAGES = 16;

    // True when a requested stage count falls inside the supported range.
    function automatic bit stages_legal(input int stages);
        return (stages >= MIN_STAGES) && (stages <= MAX_STAGES);
    endfunction

endpackage

// File: rtl/registro_etapa.sv
// One WIDTH-bit register stage with synchronous active-low reset to
// RESET_VALUE. Captures its input on every rising edge; no enable.
module registro_etapa
    import registro_datos_pkg::*;
#(
    parameter int               WIDTH       = BYTE_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next state is the incoming word, passed bit-exact.
    always_comb begin
        data_d = d_i;
    end

    // Reset wins over capture at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/registro_datos.sv
// Generic clocked data register / short delay line. STAGES identical
// register stages sit between data_in and data_out, so the latency is
// exactly STAGES cycles. data_out comes straight from the last flop.
module registro_datos
    import registro_datos_pkg::*;
#(
    parameter int               WIDTH       = BYTE_W,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    // Reject illegal configurations while elaborating, not at run time.
    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("registro_datos: STAGES=%0d outside %0d..%0d",
               STAGES, MIN_STAGES, MAX_STAGES);
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("registro_datos: WIDTH=%0d must be at least 1", WIDTH);
    end

    // chain[0] is the input word; chain[k+1] is the output of stage k.
    logic [WIDTH-1:0] chain [STAGES+1];

    assign chain[0] = data_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_etapa
        registro_etapa #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_etapa (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (chain[k]),
            .q_o   (chain[k+1])
        );
    end

    assign data_out = chain[STAGES];

endmodule

// File: tb/tb_registro_datos.sv
// Bench for registro_datos: a single-stage instance with default reset
// value and a three-stage instance resetting to 8'h5A, both fed the same
// stimulus. A history-based model predicts each output after every edge.
module tb_registro_datos;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic [7:0] out1;
    logic [7:0] out3;

    int vectors;
    int errors;

    registro_datos #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'h00)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (out1)
    );

    registro_datos #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h5A)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What was present on the inputs at each rising edge.
    logic [7:0] hist_d [0:1023];
    bit         hist_r [0:1023];
    int         ne = 0;
    int         first_rst = -1;

    always @(posedge clk) begin
        if (ne < 1024) begin
            hist_d[ne] = data_in;
            hist_r[ne] = rst_n;
        end
        if (!rst_n && first_rst < 0) first_rst = ne;
        ne = ne + 1;
    end

    // Output after edge n: RESET value if any edge in the last s edges
    // was a reset edge, otherwise the word sampled s-1 edges earlier.
    function automatic logic [7:0] model(input int s, input logic [7:0] rv, input int n);
        for (int j = n - s + 1; j <= n; j++) begin
            if (!hist_r[j]) return rv;
        end
        return hist_d[n - s + 1];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison on the falling edge once contents are defined.
    always @(negedge clk) begin
        int n;
        n = ne - 1;
        if (first_rst >= 0 && n >= first_rst && n < 1024) begin
            check("model_s1", out1, model(1, 8'h00, n));
            check("model_s3", out3, model(3, 8'h5A, n));
        end
    end

    // Present inputs, then wait until just after the next rising edge.
    task automatic step(input logic [7:0] d, input logic r);
        data_in = d;
        rst_n   = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] wrap [4];
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        data_in = 8'hA5;

        // Reset held for two edges.
        step(8'hA5, 1'b0);
        check("rst_edge1_s1", out1, 8'h00);
        check("rst_edge1_s3", out3, 8'h5A);
        step(8'hA5, 1'b0);
        check("rst_edge2_s1", out1, 8'h00);
        check("rst_edge2_s3", out3, 8'h5A);

        // Counting stream after release.
        for (int i = 0; i < 10; i++) begin
            step(8'(i), 1'b1);
            check("count_s1", out1, 8'(i));
            if (i < 2) check("count_fill_s3", out3, 8'h5A);
            else       check("count_s3", out3, 8'(i - 2));
        end

        // Wrap-around of the source value.
        wrap[0] = 8'hFE; wrap[1] = 8'hFF; wrap[2] = 8'h00; wrap[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            step(wrap[i], 1'b1);
            check("wrap_s1", out1, wrap[i]);
        end
        check("wrap_s3", out3, 8'hFF);

        // Reset for one edge in the middle of the stream.
        step(8'h37, 1'b0);
        check("midrst_s1", out1, 8'h00);
        check("midrst_s3", out3, 8'h5A);
        step(8'h38, 1'b1);
        check("after_rst_s1", out1, 8'h38);
        check("after_rst_s3", out3, 8'h5A);
        step(8'h10, 1'b1);
        check("refill_s3", out3, 8'h5A);
        step(8'h20, 1'b1);
        check("first_word_s3", out3, 8'h38);
        step(8'h30, 1'b1);
        check("delay_s3", out3, 8'h10);

        // Data and reset glitches between edges must not be captured.
        data_in = 8'h11;
        rst_n   = 1'b1;
        #1 data_in = 8'h22;
        #1 data_in = 8'h11;
        @(posedge clk);
        #2;
        check("glitch_d_s1", out1, 8'h11);
        data_in = 8'h44;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("glitch_r_s1", out1, 8'h44);
        check("glitch_r_s3", out3, 8'h30);

        // Drain the deep instance.
        step(8'h55, 1'b1);
        step(8'h66, 1'b1);
        check("drain_s3", out3, 8'h44);
        step(8'h77, 1'b1);
        check("drain2_s3", out3, 8'h55);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/registro_datos.md
Name: registro_datos

Overview:
- Generic clocked data register: captures an input word on every rising clock edge and presents it on the output after a fixed latency.
- Used in the RTC controller datapath to hold and forward byte-wide values (time/date fields, bus data) between blocks.
- Optional multi-stage mode gives a short pipeline delay line of identical registers.

Parameters:
- WIDTH, 8, bit width of data_in/data_out.
- STAGES, 1, number of register stages between data_in and data_out; legal range 1..16; latency equals STAGES clock cycles.
- RESET_VALUE, 0 (WIDTH bits), value loaded into every stage on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
- data_in  input  WIDTH  word to capture.
- data_out  output  WIDTH  registered word, driven directly from the last stage flop with no combinational path from any input.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset: rst_n = 0 at a rising edge loads RESET_VALUE into every stage. data_out = RESET_VALUE from that edge onward while reset is held.
- Reset has priority over data capture at the same edge.
- Normal operation (rst_n = 1): at each rising edge, stage 0 <= data_in and stage k <= stage k-1.
- data_out = last stage.
- No enable and no hold state: capture happens every cycle unconditionally.
- Latency is exactly STAGES cycles. With STAGES=1, data_out after edge n equals data_in sampled at edge n.
- Width rule: pure transfer, no arithmetic, no truncation or extension. All WIDTH bits are passed bit-exact.
- Wrap-around of the source, e.g. 8'hFF followed by 8'h00, is passed through unchanged.
- Reset mid-operation: all in-flight stages are cleared at the same edge.
- After reset release, the first captured word appears on data_out STAGES edges after the first edge with rst_n = 1.
- Stages still in the pipeline show RESET_VALUE until then.
- Power-up before any reset: contents are unspecified. Any edge with rst_n = 1 starts loading data normally.
- Changes on data_in between clock edges have no effect. Glitches on rst_n between edges have no effect.
- Parameter checks: STAGES < 1 or STAGES > 16, or WIDTH < 1, must cause an elaboration-time error.

Decomposition:
- No shared package is required.
- WIDTH and RESET_VALUE defaults may be taken from the project constants package if one exists (e.g. a byte-width constant of 8).
- Natural sub-module: registro_etapa, a single WIDTH-bit flop with synchronous active-low reset to RESET_VALUE.
- registro_datos instantiates STAGES copies of registro_etapa in a generate chain, plus the parameter checks.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with data_in = 8'hA5 -> data_out = 8'h00 after the first edge and stays 8'h00.
- Counting stream: release reset with a 10 ns clock; the bench drives data_in = 0,1,2,... updated at each edge -> data_out lags data_in by exactly one cycle. Example: data_out = 8'd5 in the cycle after data_in = 8'd5 is sampled.
- Wrap-around: drive 8'hFE, 8'hFF, 8'h00, 8'h01 -> data_out reproduces 8'hFE, 8'hFF, 8'h00, 8'h01 one cycle later, bit-exact.
- Reset mid-stream: assert rst_n = 0 for one edge while data_in = 8'h37 -> data_out = 8'h00 at that edge. The next edge with rst_n = 1 and data_in = 8'h38 gives data_out = 8'h38.
- Between-edge stability: toggle data_in from 8'h11 to 8'h22 and back to 8'h11 between edges -> data_out captures only the value present at the edge (8'h11) and never shows 8'h22.
- Variant STAGES=3, RESET_VALUE=8'h5A: after reset, data_out = 8'h5A for 2 edges after release. At the 3rd edge data_out equals the first post-reset data_in, and data_in = 8'h10 at edge n appears at edge n+2.
